// File: rtl/timer_pkg.sv
// Shared timer datapath definitions.
//   DEF_DIGIT_W  default digit width
//   SECS_MODULI  seconds pair {tens mod 6, units mod 10}
//   MINS_MODULI  minutes pair {tens mod 6, units mod 10}
//   modulus_of   modulus of digit i from a packed moduli vector. A slice value
//                of 0 encodes the full binary range 2**w, because that modulus
//                cannot be written in a w-bit slice.
package timer_pkg;
  localparam int DEF_DIGIT_W = 4;
  localparam int MAX_PACK_W  = 64;
  localparam logic [2*DEF_DIGIT_W-1:0] SECS_MODULI = {4'd6, 4'd10};
  localparam logic [2*DEF_DIGIT_W-1:0] MINS_MODULI = {4'd6, 4'd10};

  function automatic int modulus_of(input logic [MAX_PACK_W-1:0] moduli,
                                    input int i, input int w);
    logic [MAX_PACK_W-1:0] s;
    s = (moduli >> (i * w)) & ((MAX_PACK_W'(1) << w) - MAX_PACK_W'(1));
    return (s == '0) ? (1 << w) : int'(s);
  endfunction
endpackage

// File: rtl/modn_digit.sv
// One modulo-MOD digit with parallel load and up/down stepping.
//   clock, clr  rising-edge clock, async active-high clear
//   loadn       sync active-low load of data (clamped to MOD-1 if out of range)
//   data        load value for this digit
//   en          chain enable reaching this digit (drives tc)
//   hold        blocks stepping while leaving tc intact (saturation)
//   up          1: count up, 0: count down
//   digit       current value
//   tc          en & digit at terminal value for the current direction
//   ovr         combinational: data is not a legal digit value
module modn_digit #(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         loadn,
  input  logic [W-1:0] data,
  input  logic         en,
  input  logic         hold,
  input  logic         up,
  output logic [W-1:0] digit,
  output logic         tc,
  output logic         ovr
);
  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  logic at_term;

  assign at_term = up ? (digit == MAXV) : (digit == '0);
  assign tc      = en & at_term;
  // Extra bit lets a full-range modulus (2**W) compare without overflow.
  assign ovr     = ({1'b0, data} >= (W+1)'(MOD));

  // Terminal test happens before the step, so the digit never leaves 0..MOD-1.
  always_ff @(posedge clock or posedge clr) begin
    if (clr)
      digit <= '0;
    else if (!loadn)
      digit <= ovr ? MAXV : data;
    else if (en && !hold) begin
      if (up) digit <= at_term ? '0   : digit + W'(1);
      else    digit <= at_term ? MAXV : digit - W'(1);
    end
  end
endmodule

// File: rtl/modn_cascade_counter.sv
// Cascade of modulo-N digits for the timer/clock datapath.
//   clock     rising-edge clock
//   clr       async active-high clear; all digits and load_err -> 0
//   loadn     sync active-low parallel load of data (wins over counting)
//   data      load value, digit i in slice i
//   enable    count enable for digit 0
//   up        1: count up, 0: count down
//   count     current digit values
//   tc        per-digit terminal count (carry/borrow out), combinational
//   tc_all    chain terminal count
//   load_err  sticky flag: some load slice exceeded its modulus
module modn_cascade_counter
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] MODULI = SECS_MODULI,
  parameter bit WRAP = 1'b1
) (
  input  logic                          clock,
  input  logic                          clr,
  input  logic                          loadn,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] data,
  input  logic                          enable,
  input  logic                          up,
  output logic [NUM_DIGITS*DIGIT_W-1:0] count,
  output logic [NUM_DIGITS-1:0]         tc,
  output logic                          tc_all,
  output logic                          load_err
);
  logic                  hold;
  logic [NUM_DIGITS-1:0] ovr;

  // In saturate mode the chain freezes at its terminal; tc keeps following
  // the unfrozen enable chain so tc_all stays high while enable is held.
  assign hold   = (WRAP == 1'b0) & tc_all;
  assign tc_all = tc[NUM_DIGITS-1];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    localparam int M = modulus_of(MAX_PACK_W'(MODULI), i, DIGIT_W);

    if (M < 2 || M > (1 << DIGIT_W)) begin : g_bad
      $error("modn_cascade_counter: digit %0d modulus %0d out of range", i, M);
    end

    logic en_i;
    logic tc_i;

    // Combinational carry chain: every enabled digit steps on the same edge.
    if (i == 0) begin : g_en0
      assign en_i = enable;
    end else begin : g_enn
      assign en_i = g_dig[i-1].en_i & g_dig[i-1].tc_i;
    end

    modn_digit #(.W(DIGIT_W), .MOD(M)) u_digit (
      .clock (clock),
      .clr   (clr),
      .loadn (loadn),
      .data  (data[i*DIGIT_W +: DIGIT_W]),
      .en    (en_i),
      .hold  (hold),
      .up    (up),
      .digit (count[i*DIGIT_W +: DIGIT_W]),
      .tc    (tc_i),
      .ovr   (ovr[i])
    );

    assign tc[i] = tc_i;
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr)
      load_err <= 1'b0;
    else if (!loadn && (|ovr))
      load_err <= 1'b1;
  end
endmodule
